// File: rtl/tx_packet_scheduler.sv
// Merges power-on replies, keyboard/mouse events and mic samples into single
// 40-bit packets for the Sender, enforcing an idle gap after every transfer.
module tx_packet_scheduler #(
  parameter int KBD_DEPTH = 4,
  parameter int KBD_AW    = 2,
  parameter int GAP       = 16,
  parameter int GAP_W     = 5
) (
  input  logic              mon_clk,
  input  logic              hw_reset_n,
  input  logic              power_on_req,
  input  logic              kbd_valid,
  input  logic [16:0]       kbd_data,
  input  logic              mic_valid,
  input  logic [15:0]       mic_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [39:0]       tx_data,
  output logic [KBD_AW:0]   kbd_level,
  output logic [7:0]        kbd_drop_cnt,
  output logic [7:0]        mic_drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam bit HAS_GAP = (GAP > 0);
  localparam logic [KBD_AW:0] LEVEL_FULL = (KBD_AW + 1)'(KBD_DEPTH);

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt;
  logic              pwr_pend;
  logic              mic_full;
  logic [15:0]       mic_slot;
  logic [16:0]       kbd_mem [KBD_DEPTH];
  logic [KBD_AW-1:0] rd_ptr, wr_ptr;
  logic [KBD_AW:0]   level_q;
  logic [16:0]       kbd_head;

  logic              load, take_pwr, pop, take_mic, gap_load;
  logic [7:0]        hdr;
  logic [15:0]       payload;
  logic              push_ok, kbd_drop, mic_drop;

  assign kbd_head  = kbd_mem[rd_ptr];
  assign kbd_level = level_q;
  assign tx_valid  = (state_q == ST_SEND);

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    take_pwr = 1'b0;
    pop      = 1'b0;
    take_mic = 1'b0;
    gap_load = 1'b0;
    hdr      = 8'h00;
    payload  = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (pwr_pend) begin
          load     = 1'b1;
          take_pwr = 1'b1;
          hdr      = 8'hC0;
        end else if (level_q != '0) begin
          load    = 1'b1;
          pop     = 1'b1;
          hdr     = kbd_head[16] ? 8'hC6 : 8'hC5;
          payload = kbd_head[15:0];
        end else if (mic_full) begin
          load     = 1'b1;
          take_mic = 1'b1;
          hdr      = 8'hC7;
          payload  = mic_slot;
        end
        if (load) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (HAS_GAP) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      tx_data <= '0;
    end else if (load) begin
      tx_data <= {hdr, payload, 16'h0000};
    end
  end

  // Down-counter: loaded on handshake, GAP state exits at terminal count 1.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      gap_cnt <= '0;
    end else if (gap_load) begin
      gap_cnt <= GAP_W'(GAP);
    end else if (state_q == ST_GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // A request coinciding with consumption is a fresh request, not a merge.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) pwr_pend <= 1'b0;
    else             pwr_pend <= power_on_req | (pwr_pend & ~take_pwr);
  end

  assign push_ok  = kbd_valid & ((level_q != LEVEL_FULL) | pop);
  assign kbd_drop = kbd_valid & ~push_ok;

  always_ff @(posedge mon_clk) begin
    if (push_ok) kbd_mem[wr_ptr] <= kbd_data;
  end

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + KBD_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + KBD_AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + (KBD_AW + 1)'(1);
        2'b01:   level_q <= level_q - (KBD_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      kbd_drop_cnt <= '0;
    end else if (kbd_drop && kbd_drop_cnt != 8'hFF) begin
      kbd_drop_cnt <= kbd_drop_cnt + 8'd1;
    end
  end

  assign mic_drop = mic_valid & mic_full & ~take_mic;

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      mic_full <= 1'b0;
      mic_slot <= '0;
    end else if (mic_valid) begin
      mic_full <= 1'b1;
      mic_slot <= mic_data;
    end else if (take_mic) begin
      mic_full <= 1'b0;
    end
  end

  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      mic_drop_cnt <= '0;
    end else if (mic_drop && mic_drop_cnt != 8'hFF) begin
      mic_drop_cnt <= mic_drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler: a vector table for single-source
// packets plus hand-written priority, overflow, overwrite and reset sequences.
module tb_tx_packet_scheduler;

  logic        mon_clk;
  logic        hw_reset_n;
  logic        power_on_req;
  logic        kbd_valid;
  logic [16:0] kbd_data;
  logic        mic_valid;
  logic [15:0] mic_data;
  logic        tx_ready;
  logic        tx_valid;
  logic [39:0] tx_data;
  logic [2:0]  kbd_level;
  logic [7:0]  kbd_drop_cnt;
  logic [7:0]  mic_drop_cnt;

  tx_packet_scheduler #(
    .KBD_DEPTH(4), .KBD_AW(2), .GAP(16), .GAP_W(5)
  ) dut (
    .mon_clk      (mon_clk),
    .hw_reset_n   (hw_reset_n),
    .power_on_req (power_on_req),
    .kbd_valid    (kbd_valid),
    .kbd_data     (kbd_data),
    .mic_valid    (mic_valid),
    .mic_data     (mic_data),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .kbd_level    (kbd_level),
    .kbd_drop_cnt (kbd_drop_cnt),
    .mic_drop_cnt (mic_drop_cnt)
  );

  initial mon_clk = 1'b0;
  always #5 mon_clk = ~mon_clk;

  typedef struct {
    logic [1:0]  kind;   // 0 power-on, 1 keyboard/mouse, 2 mic
    logic [16:0] data;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs [5];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_valid(input int max, output int waited, output logic ok);
    waited = 0;
    while (!tx_valid && waited < max) begin
      tick();
      waited++;
    end
    ok = tx_valid;
  endtask

  // Waits for a packet, checks it, then lets the handshake edge pass.
  task automatic get_pkt(input string name, input logic [39:0] exp, output int waited);
    logic ok;
    wait_valid(200, waited, ok);
    check(name, {ok, tx_data}, {1'b1, exp});
    tick();
  endtask

  task automatic pulse(input logic [1:0] kind, input logic [16:0] data);
    case (kind)
      2'd0:    power_on_req = 1'b1;
      2'd1:    begin kbd_valid = 1'b1; kbd_data = data; end
      default: begin mic_valid = 1'b1; mic_data = data[15:0]; end
    endcase
    tick();
    power_on_req = 1'b0;
    kbd_valid    = 1'b0;
    mic_valid    = 1'b0;
  endtask

  initial begin
    int   w;
    int   cnt;
    logic ok;
    logic [39:0] snap;

    vecs[0] = '{kind: 2'd1, data: 17'h0_1234, exp: 40'hC5_1234_0000};
    vecs[1] = '{kind: 2'd1, data: 17'h1_00AB, exp: 40'hC6_00AB_0000};
    vecs[2] = '{kind: 2'd2, data: 17'h0_8001, exp: 40'hC7_8001_0000};
    vecs[3] = '{kind: 2'd0, data: 17'h0_0000, exp: 40'hC0_0000_0000};
    vecs[4] = '{kind: 2'd1, data: 17'h0_FFFF, exp: 40'hC5_FFFF_0000};

    hw_reset_n   = 1'b0;
    power_on_req = 1'b0;
    kbd_valid    = 1'b0;
    kbd_data     = '0;
    mic_valid    = 1'b0;
    mic_data     = '0;
    tx_ready     = 1'b1;
    repeat (3) tick();
    hw_reset_n = 1'b1;
    tick();

    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 40'h0);
    check("rst_kbd_level", kbd_level, 3'd0);
    check("rst_kbd_drop", kbd_drop_cnt, 8'd0);
    check("rst_mic_drop", mic_drop_cnt, 8'd0);

    // Pulse at N: source registered at N+1, packet valid at N+2 for one
    // cycle, then 16 gap cycles with tx_valid low.
    for (int i = 0; i < 5; i++) begin
      pulse(vecs[i].kind, vecs[i].data);
      check($sformatf("vec%0d_not_yet", i), tx_valid, 1'b0);
      tick();
      check($sformatf("vec%0d_pkt", i), {tx_valid, tx_data}, {1'b1, vecs[i].exp});
      tick();
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        if (tx_valid) cnt++;
        tick();
      end
      check($sformatf("vec%0d_one_cycle", i), cnt, 0);
      check($sformatf("vec%0d_gap_end", i), tx_valid, 1'b0);
      tick();
    end

    // Priority: all three sources in the same cycle.
    power_on_req = 1'b1;
    kbd_valid = 1'b1; kbd_data = 17'h1_00AB;
    mic_valid = 1'b1; mic_data = 16'h7FFF;
    tick();
    power_on_req = 1'b0; kbd_valid = 1'b0; mic_valid = 1'b0;
    get_pkt("prio_pwr", 40'hC0_0000_0000, w);
    get_pkt("prio_mouse", 40'hC6_00AB_0000, w);
    check("prio_gap1", w >= 16, 1'b1);
    get_pkt("prio_mic", 40'hC7_7FFF_0000, w);
    check("prio_gap2", w >= 16, 1'b1);
    repeat (20) tick();

    // FIFO overflow behind a stalled power-on packet.
    tx_ready = 1'b0;
    pulse(2'd0, '0);
    wait_valid(10, w, ok);
    for (int i = 0; i < 6; i++) begin
      kbd_valid = 1'b1;
      kbd_data  = 17'h0_0100 + 17'(i);
      tick();
    end
    kbd_valid = 1'b0;
    check("ovf_level", kbd_level, 3'd4);
    check("ovf_drop", kbd_drop_cnt, 8'd2);
    tx_ready = 1'b1;
    get_pkt("ovf_pwr", 40'hC0_0000_0000, w);
    for (int i = 0; i < 4; i++)
      get_pkt($sformatf("ovf_kbd%0d", i), {8'hC5, 16'h0100 + 16'(i), 16'h0000}, w);
    repeat (20) tick();

    // Mic overwrite while a packet is stalled.
    tx_ready = 1'b0;
    pulse(2'd0, '0);
    wait_valid(10, w, ok);
    for (int i = 1; i <= 3; i++) begin
      mic_valid = 1'b1;
      mic_data  = 16'(i);
      tick();
    end
    mic_valid = 1'b0;
    check("mic_drop", mic_drop_cnt, 8'd2);
    tx_ready = 1'b1;
    get_pkt("mic_pwr", 40'hC0_0000_0000, w);
    get_pkt("mic_last", 40'hC7_0003_0000, w);
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (tx_valid) cnt++;
      tick();
    end
    check("mic_no_extra", cnt, 0);

    // Backpressure for 50 cycles.
    tx_ready = 1'b0;
    pulse(2'd1, 17'h1_5A5A);
    wait_valid(10, w, ok);
    snap = 40'hC6_5A5A_0000;
    cnt = 0;
    for (int j = 0; j < 50; j++) begin
      if (!tx_valid || tx_data !== snap) cnt++;
      tick();
    end
    check("bp_stable", cnt, 0);
    tx_ready = 1'b1;
    cnt = 0;
    for (int j = 0; j < 40; j++) begin
      if (tx_valid && tx_ready) cnt++;
      tick();
    end
    check("bp_one_xfer", cnt, 1);

    // Reset while a keyboard packet is stalled in SEND with one more queued.
    tx_ready = 1'b0;
    pulse(2'd1, 17'h0_0777);
    pulse(2'd1, 17'h0_0888);
    wait_valid(10, w, ok);
    check("rstmid_pre", {tx_valid, tx_data, kbd_level}, {1'b1, 40'hC5_0777_0000, 3'd1});
    #3 hw_reset_n = 1'b0;
    #1;
    check("rstmid_valid", tx_valid, 1'b0);
    check("rstmid_level", kbd_level, 3'd0);
    check("rstmid_kdrop", kbd_drop_cnt, 8'd0);
    check("rstmid_mdrop", mic_drop_cnt, 8'd0);
    #2 hw_reset_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      if (tx_valid) cnt++;
      tick();
    end
    check("rstmid_no_resend", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
